// File: rtl/jk_reg_bank.sv
// WIDTH-bit programmable register bank: JK / T / D / SR per-bit semantics, change flags, sticky SR-invalid flag.
// Optional saturating change-event counter enabled by defining JK_CHG_CNT_EN.
module jk_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] chg,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_T  = 2'b01,
    MODE_D  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_sr_err;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_diff;
  logic             w_sr_inv;

  function automatic logic [WIDTH-1:0] f_mode_next(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jv,
    input logic [WIDTH-1:0] kv
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (m)
      MODE_JK: nxt = (jv & ~cur) | (~kv & cur);
      MODE_T:  nxt = cur ^ jv;
      MODE_D:  nxt = jv;
      MODE_SR: nxt = (cur | (jv & ~kv)) & ~(~jv & kv);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Next-state selection: clr > load > en > hold
  always_comb begin
    w_q_next = r_q;
    w_sr_inv = 1'b0;
    if (clr) begin
      w_q_next = RESET_VAL;
    end else if (load) begin
      w_q_next = d;
    end else if (en) begin
      w_q_next = f_mode_next(mode, r_q, j, k);
      w_sr_inv = (mode == MODE_SR) && (|(j & k));
    end
  end

  assign w_diff = w_q_next ^ r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= RESET_VAL;
      r_chg    <= '0;
      r_sr_err <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_chg <= w_diff;
      if (clr) begin
        r_sr_err <= 1'b0;
      end else if (w_sr_inv) begin
        r_sr_err <= 1'b1;
      end
    end
  end

  assign q      = r_q;
  assign q_n    = ~r_q;
  assign chg    = r_chg;
  assign sr_err = r_sr_err;

`ifdef JK_CHG_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of edges where any bit changed; a clr edge never counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if ((|w_diff) && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign chg_cnt = r_cnt;
`else
  assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed testbench for jk_reg_bank (WIDTH=8, RESET_VAL=0, CNT_W=2); counter expectations follow JK_CHG_CNT_EN.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       load;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] q;
  logic [7:0] q_n;
  logic [7:0] chg;
  logic       sr_err;
  logic [1:0] chg_cnt;

  int checks;
  int errors;

  jk_reg_bank #(
    .WIDTH    (8),
    .RESET_VAL(8'h00),
    .CNT_W    (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .load   (load),
    .mode   (mode),
    .d      (d),
    .j      (j),
    .k      (k),
    .q      (q),
    .q_n    (q_n),
    .chg    (chg),
    .sr_err (sr_err),
    .chg_cnt(chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle outputs away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] cnt_exp(input logic [1:0] v);
`ifdef JK_CHG_CNT_EN
    return v;
`else
    return 2'd0 & v;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    mode = 2'b00; d = 8'h00; j = 8'h00; k = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
    // Make sr_err and q non-zero before the mid-cycle reset
    mode = 2'b11; en = 1'b1; j = 8'hFF; k = 8'hFF;
    step();
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL pre_reset_sr_err got=%b exp=1", sr_err); end
    en = 1'b0; load = 1'b1; d = 8'h5A;
    step();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL pre_reset_load q got=%h exp=5a", q); end
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL async_reset_q got=%h exp=00", q); end
    checks++; if (q_n !== 8'hFF) begin errors++; $display("FAIL async_reset_q_n got=%h exp=ff", q_n); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL async_reset_chg got=%h exp=00", chg); end
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL async_reset_sr_err got=%b exp=0", sr_err); end
    checks++; if (chg_cnt !== 2'd0) begin errors++; $display("FAIL async_reset_cnt got=%0d exp=0", chg_cnt); end
    #1 rst_n = 1'b1;
    mode = 2'b00; j = 8'h00; k = 8'h00; d = 8'h00;
    step();
  endtask

  task automatic test_jk();
    en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h0F;
    step();
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL jk_setreset q got=%h exp=f0", q); end
    checks++; if (chg !== 8'hF0) begin errors++; $display("FAIL jk_setreset chg got=%h exp=f0", chg); end
    checks++; if (q_n !== 8'h0F) begin errors++; $display("FAIL jk_setreset q_n got=%h exp=0f", q_n); end
    j = 8'hFF; k = 8'hFF;
    step();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL jk_toggle q got=%h exp=0f", q); end
    checks++; if (chg !== 8'hFF) begin errors++; $display("FAIL jk_toggle chg got=%h exp=ff", chg); end
    j = 8'h00; k = 8'h00;
    step();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL jk_hold q got=%h exp=0f", q); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL jk_hold chg got=%h exp=00", chg); end
  endtask

  task automatic test_t_d();
    mode = 2'b01; j = 8'h3C; k = 8'h00;
    step();
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL t_mode q got=%h exp=33", q); end
    checks++; if (chg !== 8'h3C) begin errors++; $display("FAIL t_mode chg got=%h exp=3c", chg); end
    mode = 2'b10; j = 8'hA5; k = 8'hFF;
    step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL d_mode q got=%h exp=a5", q); end
    checks++; if (chg !== 8'h96) begin errors++; $display("FAIL d_mode chg got=%h exp=96", chg); end
  endtask

  task automatic test_sr_invalid();
    mode = 2'b11; j = 8'h03; k = 8'h01;
    step();
    checks++; if (q !== 8'hA7) begin errors++; $display("FAIL sr_inv q got=%h exp=a7", q); end
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL sr_inv sr_err got=%b exp=1", sr_err); end
    checks++; if (chg !== 8'h02) begin errors++; $display("FAIL sr_inv chg got=%h exp=02", chg); end
    j = 8'h00; k = 8'h00;
    step();
    checks++; if (sr_err !== 1'b1) begin errors++; $display("FAIL sr_sticky sr_err got=%b exp=1", sr_err); end
    checks++; if (q !== 8'hA7) begin errors++; $display("FAIL sr_sticky q got=%h exp=a7", q); end
    clr = 1'b1;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL sr_clr q got=%h exp=00", q); end
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL sr_clr sr_err got=%b exp=0", sr_err); end
    checks++; if (chg !== 8'hA7) begin errors++; $display("FAIL sr_clr chg got=%h exp=a7", chg); end
    clr = 1'b0;
  endtask

  task automatic test_priority();
    clr = 1'b1; load = 1'b1; en = 1'b1; d = 8'h5A; mode = 2'b00; j = 8'hFF; k = 8'hFF;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL prio_clr q got=%h exp=00", q); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL prio_clr chg got=%h exp=00", chg); end
    clr = 1'b0;
    step();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL prio_load q got=%h exp=5a", q); end
    checks++; if (chg !== 8'h5A) begin errors++; $display("FAIL prio_load chg got=%h exp=5a", chg); end
    mode = 2'b11;
    step();
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL prio_load_no_srerr got=%b exp=0", sr_err); end
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL prio_load_sr q got=%h exp=5a", q); end
    en = 1'b0; load = 1'b0;
    step();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL prio_hold q got=%h exp=5a", q); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL prio_hold chg got=%h exp=00", chg); end
  endtask

  task automatic test_chg_cnt();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd3;
    clr = 1'b1;
    step();
    checks++; if (chg_cnt !== 2'd0) begin errors++; $display("FAIL cnt_after_clr got=%0d exp=0", chg_cnt); end
    clr = 1'b0; en = 1'b1; mode = 2'b01; j = 8'h01; k = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (chg_cnt !== cnt_exp(exp_seq[i])) begin errors++; $display("FAIL cnt_edge%0d got=%0d exp=%0d", i, chg_cnt, cnt_exp(exp_seq[i])); end
      checks++; if (q !== ((i % 2 == 0) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL cnt_toggle%0d q got=%h", i, q); end
    end
    j = 8'h00;
    step();
    checks++; if (chg_cnt !== cnt_exp(2'd3)) begin errors++; $display("FAIL cnt_nochange got=%0d exp=%0d", chg_cnt, cnt_exp(2'd3)); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL cnt_nochange chg got=%h exp=00", chg); end
    j = 8'h01;
    step();
    checks++; if (chg_cnt !== cnt_exp(2'd3)) begin errors++; $display("FAIL cnt_saturate got=%0d exp=%0d", chg_cnt, cnt_exp(2'd3)); end
    clr = 1'b1;
    step();
    checks++; if (chg_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clr got=%0d exp=0", chg_cnt); end
    checks++; if (chg !== 8'h01) begin errors++; $display("FAIL cnt_clr chg got=%h exp=01", chg); end
    clr = 1'b0; en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_jk();
    test_t_d();
    test_sr_invalid();
    test_priority();
    test_chg_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
Parametrised multi-bit successor to the single JK flip-flop. WIDTH independent JK cells share one clock, one asynchronous active-low reset, and a synchronous control path. A run-time mode selects JK, T, D or SR semantics for all bits. The block adds a per-bit change flag and a sticky SR-invalid flag, and serves as the team's general-purpose programmable register primitive.

Parameters:
WIDTH, 8, number of bits/cells
RESET_VAL, {WIDTH{1'b0}}, value of q after reset or clr
CNT_W, 16, width of the optional change counter

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  enables mode-driven update
clr  input  1  synchronous clear to RESET_VAL
load  input  1  synchronous parallel load from d
mode  input  2  00 JK, 01 T, 10 D, 11 SR
d  input  WIDTH  parallel load data
j  input  WIDTH  per-bit J (T input in T mode, D input in D mode, S in SR mode)
k  input  WIDTH  per-bit K (ignored in T/D modes, R in SR mode)
q  output  WIDTH  registered state
q_n  output  WIDTH  always ~q (combinational)
chg  output  WIDTH  registered: bit i high for the cycle after an edge where q[i] changed
sr_err  output  1  sticky: SR mode saw j[i]=k[i]=1 with en on some edge
chg_cnt  output  CNT_W  change-event counter (see Optional Feature)

Behaviour:
- Single clock domain, clk. rst_n is asynchronous and active-low. Asserting rst_n at any time, including mid-cycle, immediately forces q=RESET_VAL, chg=0, sr_err=0, chg_cnt=0. Release is synchronous to clk by the integrator.
- Per rising edge, priority is clr > load > en > hold:
  - clr=1: q<=RESET_VAL, sr_err<=0, chg_cnt<=0.
  - else load=1: q<=d.
  - else en=1: per-bit update by mode.
  - else: q holds.
- JK (00): jk=00 hold, 01 reset to 0, 10 set to 1, 11 toggle.
- T (01): j[i]=1 toggles bit i, j[i]=0 holds; k ignored.
- D (10): q<=j; k ignored.
- SR (11): 00 hold, 01 reset, 10 set, 11 hold the bit and set sr_err<=1. sr_err clears only on clr or reset. It is not set when load or clr has priority on that edge.
- mode is sampled on each edge; a mode change takes effect on the same edge, with no pipeline.
- Latency: q updates on the edge that samples the inputs, i.e. one cycle. q_n is a combinational inversion with zero additional latency.
- chg<=q_next^q on every edge, including clr and load edges. chg is 0 on any edge where q does not change.
- All bits update simultaneously. There is no inter-bit coupling.

Optional Feature:
Macro JK_CHG_CNT_EN.
- Defined: chg_cnt increments by 1 on each edge where (q_next^q)!=0. It saturates at all-ones and does not wrap. clr or reset sets it to 0. A clr edge that changes q does not count, because clear wins.
- Undefined: chg_cnt is tied to 0 and no counter logic is built. The port list is unchanged.

Test Plan:
1. Reset: WIDTH=8, RESET_VAL=0x00. Drop rst_n between edges -> q=0x00, q_n=0xFF, chg=0x00, sr_err=0 immediately, without waiting for clk.
2. JK mode: from q=0x00, en=1, j=0xF0, k=0x0F -> q=0xF0, chg=0xF0. Then j=k=0xFF -> q=0x0F, chg=0xFF. Then j=k=0x00 -> q=0x0F, chg=0x00.
3. T then D: from q=0x0F, mode=01, j=0x3C -> q=0x33. Then mode=10, j=0xA5, k=0xFF -> q=0xA5.
4. SR invalid: from q=0xA5, mode=11, j=0x03, k=0x01 -> bit0 holds 1, bit1 set, q=0xA7, sr_err=1. Next, j=k=0 -> sr_err stays 1. Then clr=1 -> q=0x00, sr_err=0.
5. Priority: clr=load=en=1, d=0x5A -> q=0x00. Then load=en=1, d=0x5A, mode=00, j=0xFF, k=0xFF -> q=0x5A. Then en=0, load=0 -> q holds 0x5A, chg=0x00.
6. With JK_CHG_CNT_EN, CNT_W=2: drive 4 changing edges plus 1 non-changing edge -> chg_cnt=3 (saturated). Then clr -> chg_cnt=0. Without the macro, chg_cnt reads 0 throughout.
